// File: rtl/inv_sub_shift.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_shift
//  Description : AES inverse round front half. Applies InvShiftRows together
//                with InvSubBytes to a 128-bit state, BYTES_PER_CYC bytes per
//                clock, behind a valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_sub_shift #(
    parameter int BYTES_PER_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         out_ready
);

    // Number of BUSY edges needed to cover all 16 bytes.
    localparam int C_NUM_GROUPS = 16 / BYTES_PER_CYC;
    // Counter holds 0..C_NUM_GROUPS so the final increment never wraps.
    localparam int C_CNT_W = $clog2(C_NUM_GROUPS + 1);
    localparam logic [C_CNT_W-1:0] C_LAST_GRP = C_CNT_W'(C_NUM_GROUPS - 1);
    // Constant term of the inverse affine transform.
    localparam logic [7:0] C_INV_AFFINE_D = 8'h05;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [C_CNT_W-1:0] r_cnt;
    logic [7:0]         r_in_bytes  [16];
    logic [7:0]         r_out_bytes [16];
    logic [3:0]         w_src_idx   [BYTES_PER_CYC];
    logic [3:0]         w_dst_idx   [BYTES_PER_CYC];
    logic [7:0]         w_sub_byte  [BYTES_PER_CYC];

    // ------------------------------------------------------------------------
    // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
    // ------------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // Inverse as x^254 (x^(2+4+...+128)); maps 0 to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8] ^ C_INV_AFFINE_D[i];
        end
        return b;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(inv_affine(y));
    endfunction

    // ------------------------------------------------------------------------
    // Per-lane datapath: source byte n=(r,c) lands in column (c+r) mod 4.
    // ------------------------------------------------------------------------
    generate
        for (genvar j = 0; j < BYTES_PER_CYC; j++) begin : g_lane
            assign w_src_idx[j]  = 4'(int'(r_cnt) * BYTES_PER_CYC + j);
            assign w_dst_idx[j]  = {w_src_idx[j][3:2] + w_src_idx[j][1:0], w_src_idx[j][1:0]};
            assign w_sub_byte[j] = inv_sbox(r_in_bytes[w_src_idx[j]]);
        end
    endgenerate

    // Byte n of the flat bus occupies bits [127-8n -: 8].
    generate
        for (genvar n = 0; n < 16; n++) begin : g_pack
            assign out_state[127 - 8*n -: 8] = r_out_bytes[n];
        end
    endgenerate

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, leave BUSY after the last group,
    // release DONE on downstream acceptance.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == C_LAST_GRP) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture the input on accept, then write one group of substituted bytes
    // per BUSY edge into their shifted positions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            for (int n = 0; n < 16; n++) begin
                r_in_bytes[n]  <= 8'h00;
                r_out_bytes[n] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= '0;
                        for (int n = 0; n < 16; n++) begin
                            r_in_bytes[n] <= in_state[127 - 8*n -: 8];
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    for (int j = 0; j < BYTES_PER_CYC; j++) begin
                        r_out_bytes[w_dst_idx[j]] <= w_sub_byte[j];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_shift.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_sub_shift
//  Description : Scoreboard bench for inv_sub_shift; three instances
//                (1, 4 and 16 bytes per cycle) share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sub_shift;

    localparam int NI = 3;

    logic         clk;
    logic         rst;
    logic [127:0] in_state;
    logic         in_valid;
    logic         out_ready;
    logic         in_ready_w  [NI];
    logic [127:0] out_state_w [NI];
    logic         out_valid_w [NI];

    int           n_tests;
    int           n_fail;
    int           cyc;
    bit           rand_rdy;

    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           rd_ptr [NI];
    bit           seen   [NI];
    logic [7:0]   inv_tab [256];
    logic [127:0] snap   [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model -------------------------------------
    // Carry-less product followed by polynomial long division by 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        logic [14:0] poly;
        p = '0;
        poly = 15'h011B;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (poly << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_fwd_sbox(input logic [7:0] v);
        logic [7:0] x;
        logic [7:0] s;
        logic [7:0] c;
        x = 8'h00;
        c = 8'h63;
        for (int b = 1; b < 256; b++)
            if (ref_mul(v, 8'(b)) == 8'h01) x = 8'(b);
        for (int i = 0; i < 8; i++)
            s[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic build_tables();
        for (int v = 0; v < 256; v++) inv_tab[ref_fwd_sbox(8'(v))] = 8'(v);
    endtask

    // out(r,c) = InvSbox(in(r,(c-r) mod 4)), byte n = r + 4c.
    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [127:0] o;
        int sc;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                sc = (c - r + 4) % 4;
                o[127 - 8*(4*c + r) -: 8] = inv_tab[s[127 - 8*(4*sc + r) -: 8]];
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- DUTs and monitors ------------------------------------
    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int BPC = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
            localparam int LAT = 16 / BPC;

            inv_sub_shift #(.BYTES_PER_CYC(BPC)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_state (in_state),
                .in_valid (in_valid),
                .in_ready (in_ready_w[gi]),
                .out_state(out_state_w[gi]),
                .out_valid(out_valid_w[gi]),
                .out_ready(out_ready)
            );

            initial begin : g_mon
                forever begin
                    @(negedge clk);
                    if (!rst && out_valid_w[gi]) begin
                        n_tests++;
                        if (in_ready_w[gi]) begin
                            n_fail++;
                            $display("FAIL ready_in_done bpc=%0d in_ready=1 required 0", BPC);
                        end
                        if (rd_ptr[gi] >= exp_q.size()) begin
                            n_tests++; n_fail++;
                            $display("FAIL spurious_out bpc=%0d out_valid=1 with nothing expected", BPC);
                        end else begin
                            if (!seen[gi]) begin
                                seen[gi] = 1'b1;
                                n_tests++;
                                if (cyc - acc_q[rd_ptr[gi]] != LAT) begin
                                    n_fail++;
                                    $display("FAIL latency bpc=%0d got %0d edges required %0d",
                                             BPC, cyc - acc_q[rd_ptr[gi]], LAT);
                                end
                            end
                            if (out_ready) begin
                                n_tests++;
                                if (out_state_w[gi] !== exp_q[rd_ptr[gi]]) begin
                                    n_fail++;
                                    $display("FAIL data bpc=%0d got %h required %h",
                                             BPC, out_state_w[gi], exp_q[rd_ptr[gi]]);
                                end
                                rd_ptr[gi]++;
                                seen[gi] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // Random downstream backpressure, changed away from both clock edges.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers -------------------------------------
    function automatic bit all_ready();
        return in_ready_w[0] && in_ready_w[1] && in_ready_w[2];
    endfunction

    function automatic bit all_valid();
        return out_valid_w[0] && out_valid_w[1] && out_valid_w[2];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(posedge clk);
            #2;
            ok = all_ready();
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL wait_idle in_ready not seen on all instances within budget");
        end
    endtask

    // Called at posedge+2; returns at posedge+2 after the accept edge.
    task automatic issue(input logic [127:0] d, input logic [127:0] e);
        in_state = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        #1;
        in_valid = 1'b0;
        in_state = rand128();
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e);
        wait_idle();
        issue(d, e);
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        logic [127:0] rv;
        bit           ok;
        cyc = 0; n_tests = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b0; rand_rdy = 1'b0;
        for (int i = 0; i < NI; i++) begin rd_ptr[i] = 0; seen[i] = 1'b0; end
        build_tables();

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("reset_out_valid", 128'(out_valid_w[i]), 128'd0);
            check("reset_in_ready",  128'(in_ready_w[i]),  128'd1);
            check("reset_out_state", out_state_w[i],       128'd0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        rand_rdy = 1'b1;

        // Directed vectors with literal expectations.
        send({16{8'h63}}, 128'h0);
        send(128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
        send({8'h7c, {15{8'h63}}}, {8'h01, 120'h0});
        send({8'h63, 8'h16, {14{8'h63}}}, {40'h0, 8'hff, 80'h0});

        for (int t = 0; t < 20; t++) begin
            rv = rand128();
            send(rv, ref_model(rv));
        end

        // Backpressure: hold DONE for 10 cycles with a competing in_valid.
        wait_idle();
        rand_rdy = 1'b0;
        out_ready = 1'b0;
        rv = rand128();
        issue(rv, ref_model(rv));
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(posedge clk);
            #2;
            ok = all_valid();
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL bp_reach_done out_valid not seen on all instances within budget");
        end
        for (int i = 0; i < NI; i++) snap[i] = out_state_w[i];
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #2;
            in_valid = 1'b1;
            in_state = rand128();
            #1;
            for (int i = 0; i < NI; i++) begin
                check("bp_out_valid", 128'(out_valid_w[i]), 128'd1);
                check("bp_in_ready",  128'(in_ready_w[i]),  128'd0);
                check("bp_stable",    out_state_w[i],       snap[i]);
            end
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("bp_release_in_ready",  128'(in_ready_w[i]),  128'd1);
            check("bp_release_out_valid", 128'(out_valid_w[i]), 128'd0);
        end
        #1;
        rand_rdy = 1'b1;

        // Reset two edges into BUSY; the aborted transfer must never appear.
        wait_idle();
        rand_rdy = 1'b0;
        out_ready = 1'b0;
        rv = rand128();
        issue(rv, ref_model(rv));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_mid_out_valid", 128'(out_valid_w[i]), 128'd0);
            check("rst_mid_in_ready",  128'(in_ready_w[i]),  128'd1);
            check("rst_mid_out_state", out_state_w[i],       128'd0);
            rd_ptr[i] = exp_q.size();
            seen[i]   = 1'b0;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        rv = rand128();
        issue(rv, ref_model(rv));
        rand_rdy = 1'b1;

        // Sweep: uniform states for every byte value.
        for (int v = 0; v < 256; v++) begin
            rv = {16{8'(v)}};
            send(rv, ref_model(rv));
        end

        // Drain the scoreboard.
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(posedge clk);
            #2;
            ok = (rd_ptr[0] == exp_q.size()) && (rd_ptr[1] == exp_q.size()) &&
                 (rd_ptr[2] == exp_q.size());
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL drain outstanding results remain: %0d %0d %0d of %0d",
                     rd_ptr[0], rd_ptr[1], rd_ptr[2], exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
